// File: rtl/fsm_pkg.sv
// Shared definitions for the func issue path: func word field layout,
// opcode values and the issue FSM state encoding.
package fsm_pkg;
  localparam int FUNC_W  = 25;
  localparam int OP_MSB  = 24;
  localparam int OP_LSB  = 22;
  localparam int RX_MSB  = 21;
  localparam int RX_LSB  = 19;
  localparam int RY_MSB  = 18;
  localparam int RY_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // Every defined opcode has op[2]=0; the upper half of the space is reserved.
  function automatic logic op_reserved(input logic [2:0] op);
    return op[2];
  endfunction
endpackage

// File: rtl/func_fifo.sv
// Synchronous FIFO for buffered func words. Head word is readable
// combinationally, so it is valid during the cycle it is popped.
module func_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 25
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    push, pop;

  // full is the pre-edge value, so a write racing a pop on a full FIFO drops.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/func_issuer.sv
// Func word issuer: buffers host func words and hands them one at a time
// to the control FSM, waiting for the datapath's done between words.
// Optional watchdog on the WAIT state: define FUNC_ISSUER_TIMEOUT_EN.
module func_issuer
  import fsm_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FUNC_W    = 25,
  parameter int TO_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [FUNC_W-1:0]          wr_func,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       run,
  output logic [FUNC_W-1:0]          func,
  output logic                       new_func,
  input  logic                       done,
  output logic                       busy,
  output logic                       illegal_op,
  output logic [15:0]                issued
`ifdef FUNC_ISSUER_TIMEOUT_EN
  , output logic                     timeout
`endif
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("func_issuer: DEPTH must be a power of two >= 2");
  end
  if (TO_CYCLES < 1) begin : g_chk_to
    $error("func_issuer: TO_CYCLES must be >= 1");
  end

  state_t              state, state_n;
  logic [FUNC_W-1:0]   head;
  logic                empty, pop;
  logic                head_bad;

  func_fifo #(.DEPTH(DEPTH), .W(FUNC_W)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_data (wr_func),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign head_bad = op_reserved(head[OP_MSB:OP_LSB]);
  assign new_func = (state == S_ISSUE);
  assign busy     = (state == S_ISSUE) || (state == S_WAIT);

`ifdef FUNC_ISSUER_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_CYCLES);
  logic [TO_W-1:0] wait_cnt;
  logic            expired;

  // Expiry loses to a same-cycle done: that instruction completed.
  assign expired = (state == S_WAIT) && (wait_cnt == TO_LIM) && !done;
  assign timeout = expired;

  // Count WAIT cycles; cleared while in ISSUE so it starts at zero on entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                wait_cnt <= '0;
    else if (state == S_ISSUE)  wait_cnt <= '0;
    else if (state == S_WAIT)   wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic expired;
  assign expired = 1'b0;
`endif

  // Next state, FIFO pop and illegal-op strobe.
  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    illegal_op = 1'b0;
    unique case (state)
      S_IDLE:  if (run && !empty) state_n = S_FETCH;
      S_FETCH: begin
        pop = 1'b1;
        if (head_bad) begin
          illegal_op = 1'b1;
          state_n    = S_IDLE;
        end else begin
          state_n    = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  if (done || expired) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State, presented func word and issue counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      func   <= '0;
      issued <= '0;
    end else begin
      state <= state_n;
      if (state == S_FETCH && !head_bad) func <= head;
      if (state == S_ISSUE) issued <= issued + 16'd1;
    end
  end
endmodule

// File: tb/tb_func_issuer.sv
// Randomized self-checking bench for func_issuer. Reference model is a
// queue of accepted words plus the issue timing rules (spacing, busy window).
module tb_func_issuer;
  localparam int DEPTH = 8;
  localparam int TO    = 64;

  logic        clk = 1'b0;
  logic        resetn, wr_en, run, done;
  logic [24:0] wr_func, func;
  logic        full, new_func, busy, illegal_op;
  logic [3:0]  count;
  logic [15:0] issued;
`ifdef FUNC_ISSUER_TIMEOUT_EN
  logic        timeout;
`endif

  func_issuer #(.DEPTH(DEPTH), .FUNC_W(25), .TO_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_func(wr_func),
    .full(full), .count(count), .run(run), .func(func),
    .new_func(new_func), .done(done), .busy(busy),
    .illegal_op(illegal_op), .issued(issued)
`ifdef FUNC_ISSUER_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [24:0] q[$];
  int          exp_issued = 0;
  int          n_ill = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] gen(input bit allow_bad);
    logic [31:0] r;
    logic [2:0]  op;
    r  = $urandom;
    op = (allow_bad && $urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7))
                                                  : 3'($urandom_range(0, 3));
    return {op, r[21:0]};
  endfunction

  // One host write with run held low; model accepts while below DEPTH.
  task automatic put(input logic [24:0] w);
    run = 1'b0; wr_func = w; wr_en = 1'b1;
    tick();
    if (q.size() < DEPTH) q.push_back(w);
    check("fill_count", 32'(count), 32'(q.size()));
    check("fill_full", 32'(full), 32'(q.size() == DEPTH));
    wr_en = 1'b0;
  endtask

  task automatic fill(input int n, input bit allow_bad);
    for (int i = 0; i < n; i++) put(gen(allow_bad));
  endtask

  // Run until the model queue is empty; fd>0 fixes done latency, else random 1..4.
  task automatic drain(input int fd);
    int          cyc = 0, last = -1, last_d = 0, ill_between = 0, k = 0, d = 0;
    bit          outst = 0;
    logic [24:0] held = '0;
    run = 1'b1;
    while ((q.size() > 0 || outst) && cyc < 400) begin
      tick(); cyc++;
      done = 1'b0;
      if (illegal_op) begin
        check("illegal_head", 32'(q.size() > 0 && q[0][24]), 32'd1);
        if (q.size() > 0) void'(q.pop_front());
        ill_between++; n_ill++;
      end
      if (new_func) begin
        check("issue_overlap", 32'(outst), 32'd0);
        check("issue_queued", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          check("issue_legal", 32'(q[0][24]), 32'd0);
          check("issue_func", 32'(func), 32'(q[0]));
          void'(q.pop_front());
        end
        if (last >= 0) check("issue_spacing", 32'(cyc - last), 32'(last_d + 3 + 2 * ill_between));
        check("busy_issue", 32'(busy), 32'd1);
        last = cyc; ill_between = 0; held = func; exp_issued++;
        d = (fd > 0) ? fd : $urandom_range(1, 4);
        last_d = d; k = 0; outst = 1;
        done = 1'($urandom_range(0, 1));
      end else if (outst) begin
        k++;
        check("busy_wait", 32'(busy), 32'd1);
        check("func_stable", 32'(func), 32'(held));
        if (k == 1) check("issued_cnt", 32'(issued), 32'(exp_issued & 16'hFFFF));
        if (k == d) begin done = 1'b1; outst = 0; end
      end else begin
        check("busy_idle", 32'(busy), 32'd0);
        done = 1'($urandom_range(0, 1));
      end
    end
    if (cyc >= 400) check("drain_budget", 32'd0, 32'd1);
    tick();
    done = 1'b0;
    check("drain_count", 32'(count), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_nf(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (new_func) begin ok = 1; break; end
    end
    check("wait_new_func", 32'(ok), 32'd1);
  endtask

  initial begin
    bit ok;
    int ill0;
    resetn = 1'b0; wr_en = 1'b0; wr_func = '0; run = 1'b0; done = 1'b0;
    #15;
    check("rst_func", 32'(func), 32'd0);
    check("rst_new_func", 32'(new_func), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_issued", 32'(issued), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    @(negedge clk) resetn = 1'b1;

    // Single LOAD with done three cycles after the strobe.
    put(25'h0048000);
    drain(3);
    check("load_issued", 32'(issued), 32'd1);
    check("load_func_hold", 32'(func), 32'h0048000);

    // Back-to-back with immediate done: 4-cycle spacing.
    put(25'h0800000); put(25'h0400000); put(25'h0C00000);
    check("b2b_count", 32'(count), 32'd3);
    drain(1);

    // Nine writes into an eight-deep buffer.
    fill(9, 0);
    check("full_after9", 32'(full), 32'd1);
    drain(0);

    // Reserved opcode followed by ADD.
    ill0 = n_ill;
    put(25'h1000000); put(25'h0800000);
    drain(1);
    check("illegal_once", 32'(n_ill - ill0), 32'd1);
    check("illegal_issued", 32'(issued), 32'(exp_issued));

    // run dropped in WAIT: current instruction completes, next one holds.
    put(25'h0400000); put(25'h0C00000);
    run = 1'b1;
    wait_nf(ok);
    check("hold_func", 32'(func), 32'h0400000);
    void'(q.pop_front()); exp_issued++;
    run = 1'b0;
    tick(); done = 1'b1;
    tick(); done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (new_func) check("hold_no_issue", 32'(new_func), 32'd0);
    end
    check("hold_count", 32'(count), 32'd1);
    check("hold_busy", 32'(busy), 32'd0);
    drain(0);

    // Reset while an instruction is outstanding.
    put(25'h0048000); put(25'h0800000); put(25'h0400000);
    run = 1'b1;
    wait_nf(ok);
    tick();
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_func", 32'(func), 32'd0);
    check("mid_rst_issued", 32'(issued), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_nf", 32'(new_func), 32'd0);
    q.delete(); exp_issued = 0;
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (new_func || count != 0) check("post_rst_quiet", {new_func, 27'd0, count}, 32'd0);
    end
    check("post_rst_count", 32'(count), 32'd0);

    // Randomized rounds, including reserved ops and overfills.
    for (int r = 0; r < 15; r++) begin
      fill($urandom_range(1, 10), 1);
      drain(0);
    end

`ifdef FUNC_ISSUER_TIMEOUT_EN
    begin
      int at = -1;
      put(25'h0800000); put(25'h0400000);
      run = 1'b1;
      wait_nf(ok);
      void'(q.pop_front()); exp_issued++;
      run = 1'b0;
      for (int i = 1; i < TO + 10; i++) begin
        tick();
        if (timeout && at < 0) at = i;
      end
      check("to_cycle", 32'(at), 32'(TO + 1));
      check("to_busy", 32'(busy), 32'd0);
      drain(1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
